// File: rtl/qspi_mem_responder.sv
// QSPI memory-side target: oversampled SPI mode 0 responder serving 0xEB quad reads,
// 0x38 quad writes and 0x9F JEDEC ID from an internal byte array.
module qspi_mem_responder #(
    parameter int unsigned   MEM_BYTES    = 4096,
    parameter int unsigned   DUMMY_CYCLES = 6,
    parameter logic [23:0]   JEDEC_ID     = 24'hEF4018
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_spiClk,
    input  logic       io_CS,
    input  logic [3:0] io_inSio,
    output logic [3:0] io_outSio,
    output logic       io_dir
);
    localparam int unsigned AW         = $clog2(MEM_BYTES);
    localparam logic [7:0]  DUMMY_LAST = 8'((DUMMY_CYCLES == 0) ? 0 : DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, ID_OUT, IGNORE
    } state_t;

    logic [1:0] sclk_sync, cs_sync;
    logic [3:0] sio_meta, sio_s;
    logic       sclk_d;
    logic       rise, fall, cs_s;

    state_t          state_q, state_n, eff_state;
    logic [7:0]      cnt_q, cnt_n;
    logic [6:0]      cmd_q, cmd_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic            is_wr_q, is_wr_n;
    logic            nib_q, nib_n;
    logic [3:0]      wr_hi_q, wr_hi_n;
    logic [4:0]      id_q, id_n;
    logic [3:0]      out_q, out_n;
    logic            dir_q, dir_n;
    logic            mem_we;
    logic [7:0]      mem_wdata;
    logic [7:0]      rd_data;
    logic [7:0]      mem [MEM_BYTES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sio_meta  <= '0;
            sio_s     <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], io_spiClk};
            cs_sync   <= {cs_sync[0], io_CS};
            sio_meta  <= io_inSio;
            sio_s     <= sio_meta;
            sclk_d    <= sclk_sync[1];
        end
    end

    assign cs_s = cs_sync[1];
    assign rise = sclk_sync[1] & ~sclk_d;
    assign fall = ~sclk_sync[1] & sclk_d;

    // Memory is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[addr_q] <= mem_wdata;
        else
            rd_data <= mem[addr_q];
    end

    // A clock edge landing in the same cycle CS drops is still decoded as the first command bit.
    assign eff_state = (state_q == IDLE) ? CMD : state_q;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        cmd_n     = cmd_q;
        addr_n    = addr_q;
        is_wr_n   = is_wr_q;
        nib_n     = nib_q;
        wr_hi_n   = wr_hi_q;
        id_n      = id_q;
        out_n     = out_q;
        dir_n     = dir_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cs_s) begin
            state_n = IDLE;
            cnt_n   = '0;
            nib_n   = 1'b0;
            id_n    = '0;
            out_n   = '0;
            dir_n   = 1'b0;
        end else begin
            case (eff_state)
                CMD: begin
                    state_n = CMD;
                    if (rise) begin
                        cmd_n = {cmd_q[5:0], sio_s[0]};
                        cnt_n = cnt_q + 8'd1;
                        if (cnt_q == 8'd7) begin
                            cnt_n = '0;
                            case ({cmd_q, sio_s[0]})
                                8'hEB: begin state_n = ADDR; is_wr_n = 1'b0; end
                                8'h38: begin state_n = ADDR; is_wr_n = 1'b1; end
                                8'h9F: state_n = ID_OUT;
                                default: state_n = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: if (rise) begin
                    addr_n = AW'({addr_q, sio_s});
                    cnt_n  = cnt_q + 8'd1;
                    if (cnt_q == 8'd5) begin
                        cnt_n = '0;
                        nib_n = 1'b0;
                        if (is_wr_q)
                            state_n = WR_DATA;
                        else if (DUMMY_CYCLES == 0)
                            state_n = RD_DATA;
                        else
                            state_n = DUMMY;
                    end
                end
                DUMMY: if (rise) begin
                    cnt_n = cnt_q + 8'd1;
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_n   = '0;
                        state_n = RD_DATA;
                    end
                end
                RD_DATA: if (fall) begin
                    dir_n = 1'b1;
                    nib_n = ~nib_q;
                    if (nib_q) begin
                        out_n  = rd_data[3:0];
                        addr_n = addr_q + AW'(1);
                    end else begin
                        out_n = rd_data[7:4];
                    end
                end
                WR_DATA: if (rise) begin
                    nib_n = ~nib_q;
                    if (nib_q) begin
                        mem_we    = 1'b1;
                        mem_wdata = {wr_hi_q, sio_s};
                        addr_n    = addr_q + AW'(1);
                    end else begin
                        wr_hi_n = sio_s;
                    end
                end
                ID_OUT: if (fall) begin
                    dir_n = 1'b1;
                    out_n = {2'b00, JEDEC_ID[5'd23 - id_q], 1'b0};
                    id_n  = (id_q == 5'd23) ? 5'd0 : id_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            is_wr_q <= 1'b0;
            nib_q   <= 1'b0;
            wr_hi_q <= '0;
            id_q    <= '0;
            out_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            cmd_q   <= cmd_n;
            addr_q  <= addr_n;
            is_wr_q <= is_wr_n;
            nib_q   <= nib_n;
            wr_hi_q <= wr_hi_n;
            id_q    <= id_n;
            out_q   <= out_n;
            dir_q   <= dir_n;
        end
    end

    assign io_outSio = out_q;
    assign io_dir    = dir_q;
endmodule

// File: tb/tb_qspi_mem_responder.sv
// Bench for qspi_mem_responder: drives the QSPI pins like the controller and scoreboards
// returned nibbles against a shadow copy of the memory.
module tb_qspi_mem_responder;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_spiClk = 1'b0;
    logic       io_CS = 1'b1;
    logic [3:0] io_inSio = '0;
    logic [3:0] io_outSio;
    logic       io_dir;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  model [4096];
    logic [7:0]  wbuf [8];
    logic [3:0]  exp_q [$];

    qspi_mem_responder #(.MEM_BYTES(4096), .DUMMY_CYCLES(6), .JEDEC_ID(24'hEF4018)) dut (
        .clock(clock), .reset(reset), .io_spiClk(io_spiClk), .io_CS(io_CS),
        .io_inSio(io_inSio), .io_outSio(io_outSio), .io_dir(io_dir)
    );

    always #5 clock = ~clock;

    // One full SPI cycle; the sample taken late in the low phase reflects the previous fall.
    task automatic spi_cycle(input logic [3:0] d, output logic [3:0] so, output logic dr);
        io_inSio = d;
        repeat (5) @(posedge clock);
        @(negedge clock);
        so = io_outSio;
        dr = io_dir;
        @(posedge clock);
        #1 io_spiClk = 1'b1;
        repeat (5) @(posedge clock);
        #1 io_spiClk = 1'b0;
    endtask

    task automatic cs_begin();
        @(posedge clock);
        #1 io_CS = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic cs_rise();
        @(posedge clock);
        #1 io_CS = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] so;
        logic       dr;
        for (int i = 7; i >= 0; i--) spi_cycle({3'b000, b[i]}, so, dr);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [3:0] so;
        logic       dr;
        for (int i = 5; i >= 0; i--) spi_cycle(a[4*i +: 4], so, dr);
    endtask

    task automatic start_read(input logic [23:0] a);
        logic [3:0] so;
        logic       dr;
        cs_begin();
        send_byte(8'hEB);
        send_addr(a);
        for (int i = 0; i < 6; i++) spi_cycle(4'h0, so, dr);
    endtask

    task automatic write_burst(input logic [23:0] a, input int n);
        logic [3:0] so;
        logic       dr;
        cs_begin();
        send_byte(8'h38);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            spi_cycle(wbuf[i][7:4], so, dr);
            spi_cycle(wbuf[i][3:0], so, dr);
            model[(a[11:0] + 12'(i))] = wbuf[i];
        end
        cs_rise();
        repeat (4) @(posedge clock);
    endtask

    task automatic push_bytes(input logic [11:0] a, input int n);
        logic [11:0] p;
        p = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model[p][7:4]);
            exp_q.push_back(model[p][3:0]);
            p = p + 12'd1;
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (io_dir !== 1'b0 || io_outSio !== 4'h0) begin
            n_err++;
            $display("FAIL reset_state: dir=%b out=%h, required dir=0 out=0", io_dir, io_outSio);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_write_read();
        logic [3:0] so, e;
        logic       dr;
        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h3C;
        write_burst(24'h000010, 2);
        push_bytes(12'h010, 2);
        start_read(24'h000010);
        while (exp_q.size() > 0) begin
            spi_cycle(4'h0, so, dr);
            e = exp_q.pop_front();
            n_vec++;
            if (so !== e || dr !== 1'b1) begin
                n_err++;
                $display("FAIL write_read_nibble: out=%h dir=%b, required out=%h dir=1", so, dr, e);
            end
        end
        cs_rise();
        n_vec++;
        if (io_dir !== 1'b0) begin
            n_err++;
            $display("FAIL read_cs_release: dir=%b, required 0", io_dir);
        end
        repeat (4) @(posedge clock);
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] so, e;
        logic       dr;
        start_read(24'h000010);
        spi_cycle(4'h0, so, dr);
        n_vec++;
        if (dr !== 1'b1) begin
            n_err++;
            $display("FAIL mid_read_dir: dir=%b, required 1", dr);
        end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (io_dir !== 1'b0 || io_outSio !== 4'h0) begin
            n_err++;
            $display("FAIL async_reset: dir=%b out=%h, required dir=0 out=0", io_dir, io_outSio);
        end
        io_spiClk = 1'b0;
        io_CS = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        push_bytes(12'h010, 2);
        start_read(24'h000010);
        while (exp_q.size() > 0) begin
            spi_cycle(4'h0, so, dr);
            e = exp_q.pop_front();
            n_vec++;
            if (so !== e || dr !== 1'b1) begin
                n_err++;
                $display("FAIL post_reset_read: out=%h dir=%b, required out=%h dir=1", so, dr, e);
            end
        end
        cs_rise();
        repeat (4) @(posedge clock);
    endtask

    task automatic test_wrap();
        logic [3:0] so, e;
        logic       dr;
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        write_burst(24'h000FFF, 2);
        push_bytes(12'hFFF, 2);
        start_read(24'h000FFF);
        while (exp_q.size() > 0) begin
            spi_cycle(4'h0, so, dr);
            e = exp_q.pop_front();
            n_vec++;
            if (so !== e || dr !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_read: out=%h dir=%b, required out=%h dir=1", so, dr, e);
            end
        end
        cs_rise();
        repeat (4) @(posedge clock);
    endtask

    task automatic test_jedec();
        logic [3:0]  so, e;
        logic        dr;
        logic [23:0] id;
        id = 24'hEF4018;
        for (int k = 0; k < 48; k++) exp_q.push_back({2'b00, id[23 - (k % 24)], 1'b0});
        cs_begin();
        send_byte(8'h9F);
        while (exp_q.size() > 0) begin
            spi_cycle(4'h0, so, dr);
            e = exp_q.pop_front();
            n_vec++;
            if (so !== e || dr !== 1'b1) begin
                n_err++;
                $display("FAIL jedec_bit: out=%h dir=%b, required out=%h dir=1", so, dr, e);
            end
        end
        cs_rise();
        repeat (4) @(posedge clock);
    endtask

    task automatic test_unknown_cmd();
        logic [3:0] so, e;
        logic       dr;
        cs_begin();
        send_byte(8'h5A);
        for (int i = 0; i < 3; i++) begin
            spi_cycle(4'hF, so, dr);
            n_vec++;
            if (dr !== 1'b0 || so !== 4'h0) begin
                n_err++;
                $display("FAIL ignore_state: out=%h dir=%b, required out=0 dir=0", so, dr);
            end
        end
        cs_rise();
        repeat (4) @(posedge clock);
        push_bytes(12'h010, 2);
        start_read(24'h000010);
        while (exp_q.size() > 0) begin
            spi_cycle(4'h0, so, dr);
            e = exp_q.pop_front();
            n_vec++;
            if (so !== e) begin
                n_err++;
                $display("FAIL ignore_mem_kept: out=%h, required %h", so, e);
            end
        end
        cs_rise();
        repeat (4) @(posedge clock);
    endtask

    task automatic test_partial_write();
        logic [3:0] so, e;
        logic       dr;
        wbuf[0] = 8'h77;
        wbuf[1] = 8'h88;
        write_burst(24'h000020, 2);
        cs_begin();
        send_byte(8'h38);
        send_addr(24'h000020);
        spi_cycle(4'h1, so, dr);
        spi_cycle(4'h2, so, dr);
        spi_cycle(4'h3, so, dr);
        model[12'h020] = 8'h12;
        cs_rise();
        n_vec++;
        if (io_dir !== 1'b0) begin
            n_err++;
            $display("FAIL partial_cs_release: dir=%b, required 0", io_dir);
        end
        repeat (4) @(posedge clock);
        push_bytes(12'h020, 2);
        start_read(24'h000020);
        while (exp_q.size() > 0) begin
            spi_cycle(4'h0, so, dr);
            e = exp_q.pop_front();
            n_vec++;
            if (so !== e) begin
                n_err++;
                $display("FAIL partial_write_read: out=%h, required %h", so, e);
            end
        end
        cs_rise();
        repeat (4) @(posedge clock);
    endtask

    task automatic test_back_to_back();
        logic [3:0] so, e;
        logic       dr;
        for (int i = 0; i < 6; i++) wbuf[i] = 8'($urandom_range(0, 255));
        write_burst(24'h123456, 6);
        push_bytes(12'h456, 6);
        start_read(24'hFFF456);
        while (exp_q.size() > 0) begin
            spi_cycle(4'h0, so, dr);
            e = exp_q.pop_front();
            n_vec++;
            if (so !== e || dr !== 1'b1) begin
                n_err++;
                $display("FAIL burst_read: out=%h dir=%b, required out=%h dir=1", so, dr, e);
            end
        end
        cs_rise();
        repeat (4) @(posedge clock);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_mid_read();
        test_wrap();
        test_jedec();
        test_unknown_cmd();
        test_partial_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
